pio_gpio_n: RTL
===============

// Module: pio_gpio_n
// PURPOSE
//  Parametrised Avalon-MM GPIO port, successor of the fixed 8-pin PIO.
//  WIDTH bidirectional pins with per-pin direction and atomic set/clear.
//  Inputs pass through a synchroniser; configurable edge capture raises a maskable, level interrupt.
//  Sits on the system Avalon bus like the other qsys_root peripherals.
// PARAMETERS
//  WIDTH        8             number of pins, 1..32
//  SYNC_STAGES  2             input synchroniser depth, 2..3
//  EDGE_MODE    2             0 rising, 1 falling, 2 both edges
//  SIGNATURE    32'hEA680002  value returned at address 1
// PORTS
//  csi_MCLK_clk          in     1      clock
//  rsi_MRST_reset        in     1      asynchronous reset, active-high
//  avs_gpio_address      in     3      word address
//  avs_gpio_writedata    in     32     write data
//  avs_gpio_byteenable   in     4      byte lanes for writes
//  avs_gpio_write        in     1      write strobe
//  avs_gpio_read         in     1      read strobe (unused; readdata is free-running)
//  avs_gpio_readdata     out    32     registered read data
//  avs_gpio_waitrequest  out    1      tied 0
//  ins_gpio_irq          out    1      interrupt, level, active-high
//  coe_pio               inout  WIDTH  pins
// BEHAVIOUR
//  Reset is async, active-high, on csi_MCLK_clk. At reset all registers = 0:
//   readdata=0, dir=0 (all inputs), data=0, mask=0, capture=0, irq=0, sync chain=0, prime counter=0.
//  Pin drive: coe_pio[i] = dir[i] ? data[i] : 1'bz.
//  Readdata: registered every cycle from address, fixed 1-cycle latency (readLatency=1).
//   Bits above WIDTH read as 0.
//  Register map:
//   0  R   WIDTH
//   1  R   SIGNATURE
//   2  RW  dir; 1 = output
//   3  RW  write data reg; read returns synchronised pin state (pin_s)
//   4  W   set: data |= wdata; read returns data reg
//   5  W   clear: data &= ~wdata; read returns data reg
//   6  RW  irq mask
//   7  RW1C  edge capture; read = capture
//  Writes: honour byteenable per lane on every writable address; disabled lanes leave bits unchanged.
//   Writes to 0/1 are ignored.
//  Sync: pin_s = last stage of the SYNC_STAGES flop chain; prev = pin_s delayed 1 cycle.
//  Edge detect: rise = pin_s & ~prev; fall = ~pin_s & prev; selected by EDGE_MODE.
//   Applies to all pins regardless of dir.
//  Prime: a counter suppresses edge detection until SYNC_STAGES+1 cycles after reset release.
//   Pins already high at reset therefore produce no spurious capture.
//  Capture: capture[i] <= (capture[i] & ~clr[i]) | edge[i]; clr comes from a byte-enabled W1C at addr 7.
//   If an edge and a clear hit the same bit in the same cycle, the edge wins (bit stays 1).
//  IRQ: ins_gpio_irq registered, = |(capture & mask), one cycle after capture/mask update.
//   Level output; deasserts only after the capture bits are cleared or masked.
//  Edge latency: pin toggle -> capture bit set in SYNC_STAGES+1 cycles -> irq one cycle later.
//  Reset mid-operation: immediately tristates all pins and drops irq; no pending edge survives.
// STRUCTURE
//  Shared package pio_pkg:
//   address constants ADDR_WIDTH_ID..ADDR_CAPTURE, EDGE_RISE/EDGE_FALL/EDGE_BOTH encodings.
//  Sub-module pio_sync_edge: per-bus synchroniser, prev register, prime counter, edge output.
//  Top level holds the register file, read mux, capture/irq logic and tristates.
// TESTING
//  1. Read addr 0/1 after reset -> 8, 32'hEA680002 one cycle later. Read addr 2 -> 0; pins all Z.
//  2. Write dir=0xFF, data=0xA5 -> pins 0xA5; set 0x0A -> 0xAF; clear 0x81 -> 0x2E.
//     Byteenable=0 write changes nothing.
//  3. External drive 0x01->0x03 on inputs, EDGE_MODE=2 -> capture=0x02 after SYNC_STAGES+1 cycles.
//     With mask=0x02, irq=1 one cycle later.
//  4. W1C 0x02 to addr 7 in the same cycle a new edge on pin 1 -> capture bit stays 1, irq stays 1.
//     Plain W1C afterwards -> irq=0 next cycle.
//  5. Hold pin 3 high through reset release -> no capture bit set. Falling edge later sets bit 3 (EDGE_MODE=2).
//  6. Assert reset while driving outputs with irq=1 -> pins Z, irq=0, readdata=0 immediately.
//     WIDTH=32 build: addr 0 reads 32, full-width set/clear works.

Source files
------------

// File: rtl/pio_pkg.sv
// Shared definitions for the parametrised GPIO port: register map, edge-mode
// encodings and the Avalon byte-lane expansion helper.
package pio_pkg;

    typedef enum logic [2:0] {
        ADDR_WIDTH_ID  = 3'd0,
        ADDR_SIGNATURE = 3'd1,
        ADDR_DIR       = 3'd2,
        ADDR_DATA      = 3'd3,
        ADDR_SET       = 3'd4,
        ADDR_CLEAR     = 3'd5,
        ADDR_MASK      = 3'd6,
        ADDR_CAPTURE   = 3'd7
    } gpio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_BOTH = 2;

    // Expands the 4 Avalon byte enables into a 32-bit bit mask.
    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/pio_sync_edge.sv
// Input synchroniser with a one-cycle history register and a post-reset prime
// counter, producing the synchronised pin bus and the selected edge pulses.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = EDGE_BOTH
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MRST_reset,
    input  logic [WIDTH-1:0] pin_async,
    output logic [WIDTH-1:0] pin_s,
    output logic [WIDTH-1:0] edge_det
);

    localparam int PRIME_CYCLES = SYNC_STAGES + 1;

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [2:0]       prime_q;
    logic             primed;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q  <= '0;
            prime_q <= '0;
        end else begin
            sync_q[0] <= pin_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= pin_s;
            if (!primed) begin
                prime_q <= prime_q + 3'd1;
            end
        end
    end

    assign pin_s  = sync_q[SYNC_STAGES-1];
    // Edges stay masked until the chain and prev hold real post-reset samples,
    // so pins already high at reset release do not look like rising edges.
    assign primed = (prime_q == 3'(PRIME_CYCLES));
    assign rise   = pin_s & ~prev_q;
    assign fall   = ~pin_s & prev_q;

    always_comb begin
        edge_det = '0;
        if (primed) begin
            case (EDGE_MODE)
                EDGE_RISE: edge_det = rise;
                EDGE_FALL: edge_det = fall;
                default:   edge_det = rise | fall;
            endcase
        end
    end

endmodule

// File: rtl/pio_gpio_n.sv
// Avalon-MM GPIO port: WIDTH bidirectional pins with direction, atomic
// set/clear, synchronised inputs, edge capture and a maskable level interrupt.
module pio_gpio_n
    import pio_pkg::*;
#(
    parameter int          WIDTH       = 8,
    parameter int          SYNC_STAGES = 2,
    parameter int          EDGE_MODE   = EDGE_BOTH,
    parameter logic [31:0] SIGNATURE   = 32'hEA680002
) (
    input  logic             csi_MCLK_clk,
    input  logic             rsi_MRST_reset,
    input  logic [2:0]       avs_gpio_address,
    input  logic [31:0]      avs_gpio_writedata,
    input  logic [3:0]       avs_gpio_byteenable,
    input  logic             avs_gpio_write,
    input  logic             avs_gpio_read,
    output logic [31:0]      avs_gpio_readdata,
    output logic             avs_gpio_waitrequest,
    output logic             ins_gpio_irq,
    inout  wire  [WIDTH-1:0] coe_pio
);

    // Avalon slave handshake: a write is taken in any cycle avs_gpio_write is
    // high (waitrequest is never asserted); readdata is registered from the
    // address every cycle, so it shows the previous cycle's address.

    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] mask_q;
    logic [WIDTH-1:0] cap_q;
    logic             irq_q;
    logic [31:0]      rd_q;
    logic [31:0]      rd_next;

    logic [31:0]      be32;
    logic [31:0]      wd32;
    logic [WIDTH-1:0] wmask;
    logic [WIDTH-1:0] wbits;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] pin_s;
    logic [WIDTH-1:0] edge_det;
    logic             unused_ok;

    logic wr_dir, wr_data, wr_set, wr_clear, wr_mask, wr_cap;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_MODE   (EDGE_MODE)
    ) u_sync_edge (
        .csi_MCLK_clk   (csi_MCLK_clk),
        .rsi_MRST_reset (rsi_MRST_reset),
        .pin_async      (coe_pio),
        .pin_s          (pin_s),
        .edge_det       (edge_det)
    );

    assign be32  = lane_mask(avs_gpio_byteenable);
    assign wd32  = avs_gpio_writedata & be32;
    assign wmask = be32[WIDTH-1:0];
    assign wbits = wd32[WIDTH-1:0];

    assign wr_dir   = avs_gpio_write && (avs_gpio_address == ADDR_DIR);
    assign wr_data  = avs_gpio_write && (avs_gpio_address == ADDR_DATA);
    assign wr_set   = avs_gpio_write && (avs_gpio_address == ADDR_SET);
    assign wr_clear = avs_gpio_write && (avs_gpio_address == ADDR_CLEAR);
    assign wr_mask  = avs_gpio_write && (avs_gpio_address == ADDR_MASK);
    assign wr_cap   = avs_gpio_write && (avs_gpio_address == ADDR_CAPTURE);

    assign clr = wr_cap ? wbits : '0;

    always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
        if (rsi_MRST_reset) begin
            dir_q  <= '0;
            data_q <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            irq_q  <= 1'b0;
            rd_q   <= '0;
        end else begin
            if (wr_dir) begin
                dir_q <= (dir_q & ~wmask) | wbits;
            end
            if (wr_data) begin
                data_q <= (data_q & ~wmask) | wbits;
            end else if (wr_set) begin
                data_q <= data_q | wbits;
            end else if (wr_clear) begin
                data_q <= data_q & ~wbits;
            end
            if (wr_mask) begin
                mask_q <= (mask_q & ~wmask) | wbits;
            end
            // A new edge wins over a simultaneous W1C on the same bit.
            cap_q <= (cap_q & ~clr) | edge_det;
            irq_q <= |(cap_q & mask_q);
            rd_q  <= rd_next;
        end
    end

    always_comb begin
        rd_next = '0;
        case (gpio_addr_e'(avs_gpio_address))
            ADDR_WIDTH_ID:  rd_next = 32'(WIDTH);
            ADDR_SIGNATURE: rd_next = SIGNATURE;
            ADDR_DIR:       rd_next = 32'(dir_q);
            ADDR_DATA:      rd_next = 32'(pin_s);
            ADDR_SET:       rd_next = 32'(data_q);
            ADDR_CLEAR:     rd_next = 32'(data_q);
            ADDR_MASK:      rd_next = 32'(mask_q);
            ADDR_CAPTURE:   rd_next = 32'(cap_q);
            default:        rd_next = '0;
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        assign coe_pio[i] = dir_q[i] ? data_q[i] : 1'bz;
    end

    assign avs_gpio_readdata    = rd_q;
    assign avs_gpio_waitrequest = 1'b0;
    assign ins_gpio_irq         = irq_q;
    assign unused_ok            = ^{avs_gpio_read, wd32, be32};

endmodule
